disp_scan_ctrl: RTL and testbench

//  Upstream scan controller for the 4-digit, 4-bit 4:1 display mux. Holds a 16-bit display word
//  and presents it to the mux as four nibble buses I0..I3. Drives the mux select s round-robin
//  and drives active-low digit anodes an. A dead-time gap between digits suppresses ghosting.
//  The mux output feeds the hex-to-7-seg decoder downstream.

---
 rtl/disp_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scan controller for a 4-digit multiplexed display.
//
// Holds a 16-bit display word and presents it as four nibble buses (I0..I3) to a 4:1
// mux. It steps the mux select round-robin and drives the active-low digit anodes.
// A blanking gap between digits gives the mux time to settle while every anode is dark.
// A new word is staged in a pending register, then committed when the scanner is idle
// or at a frame boundary, so a lit digit never changes part-way through a frame.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; low forces the display dark
//   load        1-cycle strobe to capture din into the pending register
//   din         display word, din[3:0] = digit0 ... din[15:12] = digit3
//   blank_mask  bit k set keeps digit k dark during its slot
//   s           mux select / current digit index
//   I0..I3      committed nibbles for the mux
//   an          digit anodes, active low, one-hot-low when lit
//   frame_done  1-cycle pulse after s wraps from 3 to 0
module disp_scan_ctrl #(
  parameter int unsigned DIV  = 4,  // cycles each digit is lit
  parameter int unsigned DEAD = 1   // blanking cycles between digits
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  blank_mask,
  output logic [1:0]  s,
  output logic [3:0]  I0,
  output logic [3:0]  I1,
  output logic [3:0]  I2,
  output logic [3:0]  I3,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CntMax = (DIV > DEAD) ? DIV : DEAD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DivLast  = CntW'(DIV - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD - 1);

  typedef enum logic [1:0] {StIdle, StOn, StDead} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      s_q, s_d;
  logic [3:0]      an_q, an_d;
  logic            fd_q, fd_d;
  logic            pend_q, pend_d;
  logic [15:0]     pend_word_q, pend_word_d;
  logic [15:0]     disp_q, disp_d;
  logic            commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      s_q         <= 2'd0;
      an_q        <= 4'b1111;
      fd_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_word_q <= 16'h0000;
      disp_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      disp_q      <= disp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    fd_d        = 1'b0;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    disp_d      = disp_q;
    commit      = 1'b0;
    an_d        = 4'b1111;

    if (!en) begin
      // Dropping enable parks the scanner; s is held so re-enable resumes the same digit.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StOn;
          cnt_d   = '0;
        end
        StOn: begin
          if (cnt_q == DivLast) begin
            // Advance s on entry to the dark gap so the mux settles before the next digit.
            state_d = StDead;
            cnt_d   = '0;
            s_d     = s_q + 2'd1;
            if (s_q == 2'd3) begin
              fd_d   = 1'b1;
              commit = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDead: begin
          if (cnt_q == DeadLast) begin
            state_d = StOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    // Nothing is lit while idle, so a staged word can be committed at once.
    if (state_q == StIdle) begin
      commit = 1'b1;
    end

    if (commit && pend_q) begin
      disp_d = pend_word_q;
      pend_d = 1'b0;
    end

    // A load on a commit edge wins over the clear and waits for the next opportunity.
    if (load) begin
      pend_word_d = din;
      pend_d      = 1'b1;
    end

    // The anode register follows the state being entered, so an changes on that edge.
    if ((state_d == StOn) && !blank_mask[s_d]) begin
      an_d = ~(4'b0001 << s_d);
    end
  end

  assign s          = s_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign I0         = disp_q[3:0];
  assign I1         = disp_q[7:4];
  assign I2         = disp_q[11:8];
  assign I3         = disp_q[15:12];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Testbench for disp_scan_ctrl (DIV=4, DEAD=1). The stimulus process pushes the
// expected outputs for the next clock edge into a queue tagged with the cycle number.
// A separate monitor pops and compares them on the falling edge.
module tb_disp_scan_ctrl;

  localparam int unsigned DIV    = 4;
  localparam int unsigned DEAD   = 1;
  localparam int          Period = DIV + DEAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] din;
  logic [3:0]  blank_mask;
  logic [1:0]  s;
  logic [3:0]  I0, I1, I2, I3;
  logic [3:0]  an;
  logic        frame_done;

  disp_scan_ctrl #(
    .DIV  (DIV),
    .DEAD (DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .blank_mask (blank_mask),
    .s          (s),
    .I0         (I0),
    .I1         (I1),
    .I2         (I2),
    .I3         (I3),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    int          cyc;
    int          tid;
    int          step;
    logic [3:0]  an;
    logic [1:0]  s;
    logic [15:0] iw;
    logic        fd;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic cmp_field(input int tid, input int step, input string fld,
                           input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL t%0d.%0d %s: got %h, want %h", tid, step, fld, act, req);
    end
  endtask

  task automatic check_all(input int tid, input int step, input logic [3:0] an_e,
                           input logic [1:0] s_e, input logic [15:0] iw_e, input logic fd_e);
    cmp_field(tid, step, "an", {12'h000, an}, {12'h000, an_e});
    cmp_field(tid, step, "s", {14'h0000, s}, {14'h0000, s_e});
    cmp_field(tid, step, "I3..I0", {I3, I2, I1, I0}, iw_e);
    cmp_field(tid, step, "frame_done", {15'h0000, frame_done}, {15'h0000, fd_e});
  endtask

  // Expected outputs after the next rising edge.
  task automatic expect_out(input int tid, input int step, input logic [3:0] an_e,
                            input logic [1:0] s_e, input logic [15:0] iw_e, input logic fd_e);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.tid  = tid;
    e.step = step;
    e.an   = an_e;
    e.s    = s_e;
    e.iw   = iw_e;
    e.fd   = fd_e;
    sb.push_back(e);
  endtask

  // Edge k after enabling from digit s0: phases 0..DIV-1 are lit, the remainder is the
  // dark gap, during which s already shows the following digit.
  task automatic expect_scan(input int tid, input int k, input int s0, input logic [15:0] iw_e);
    int         phase;
    int         slot;
    int         digit;
    logic       lit;
    logic [1:0] s_e;
    logic [3:0] an_e;
    logic       fd_e;
    phase = k % Period;
    slot  = k / Period;
    lit   = (phase < int'(DIV));
    digit = lit ? (s0 + slot) % 4 : (s0 + slot + 1) % 4;
    s_e   = 2'(digit);
    an_e  = (lit && !blank_mask[s_e]) ? ~(4'b0001 << s_e) : 4'b1111;
    fd_e  = !lit && ((s0 + slot) % 4 == 3);
    expect_out(tid, k, an_e, s_e, iw_e, fd_e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc_cnt) begin
        n_cmp++;
        n_bad++;
        $display("FAIL t%0d.%0d stale: due cycle %0d, seen at %0d",
                 mon_e.tid, mon_e.step, mon_e.cyc, cyc_cnt);
      end else begin
        check_all(mon_e.tid, mon_e.step, mon_e.an, mon_e.s, mon_e.iw, mon_e.fd);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    en         = 1'b0;
    load       = 1'b0;
    din        = 16'h0000;
    blank_mask = 4'b0000;
    #1 rst_n = 1'b0;
    #1 check_all(0, 0, 4'b1111, 2'd0, 16'h0000, 1'b0);
    #10 rst_n = 1'b1;

    // 1: idle after reset with scanning disabled.
    for (int i = 0; i < 10; i++) begin
      expect_out(1, i, 4'b1111, 2'd0, 16'h0000, 1'b0);
      next_cycle();
    end

    // 2: two loads in idle; the second lands on the first one's commit edge.
    load = 1'b1;
    din  = 16'hFFFF;
    expect_out(2, 100, 4'b1111, 2'd0, 16'h0000, 1'b0);
    next_cycle();
    din = 16'h3210;
    expect_out(2, 101, 4'b1111, 2'd0, 16'hFFFF, 1'b0);
    next_cycle();
    load = 1'b0;
    en   = 1'b1;
    // 2/3: two full frames, then a mid-frame load while digit 1 is lit.
    for (int k = 0; k < 60; k++) begin
      load = (k == 46);
      if (k == 46) din = 16'hABCD;
      expect_scan((k < 40) ? 2 : 3, k, 0, (k >= 59) ? 16'hABCD : 16'h3210);
      next_cycle();
    end
    load = 1'b0;

    // 4: digit 2 blanked for one frame.
    blank_mask = 4'b0100;
    for (int k = 60; k < 80; k++) begin
      expect_scan(4, k, 0, 16'hABCD);
      next_cycle();
    end
    blank_mask = 4'b0000;

    // 5: drop enable while digit 2 is lit, then resume it with a full on-time.
    for (int k = 80; k < 91; k++) begin
      expect_scan(5, k, 0, 16'hABCD);
      next_cycle();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out(5, 200 + i, 4'b1111, 2'd2, 16'hABCD, 1'b0);
      next_cycle();
    end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      load = (k == 1);
      if (k == 1) din = 16'h1234;
      expect_scan(5, 300 + k - 300 + k * 0 + 0 == k ? k : k, 2, 16'hABCD);
      next_cycle();
    end
    load = 1'b0;

    // 6: asynchronous reset between edges in the dark gap, with a load pending.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all(6, 0, 4'b1111, 2'd0, 16'h0000, 1'b0);
    en = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out(6, 10 + i, 4'b1111, 2'd0, 16'h0000, 1'b0);
      next_cycle();
    end
    en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      expect_scan(6, 100 + k - 100 + 0 == k ? k : k, 0, 16'h0000);
      next_cycle();
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
